job_controller: RTL and testbench

- Parametrised job-control engine for CAPI AFUs. It replaces the ad-hoc RESET-to-done logic in the AFU top level.
- Decodes PSL job commands (RESET, START, others), sequences an internal core reset, and tracks the running state.
- Captures the WED on START and reports completion or error back to the PSL through the job interface.
- Sits between the PSL job interface and the AFU datapath core.

---
 rtl/job_controller_pkg.sv | 36 +++
 rtl/job_controller_shift.sv | 26 ++
 rtl/job_controller.sv | 130 +++++++++++++
 tb/tb_job_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/job_controller_pkg.sv
// rtl/job_controller_pkg.sv - PSL job interface types, job commands and controller state encoding
package job_controller_pkg;

    typedef enum logic [7:0] {
        CMD_TIMEBASE = 8'h42,
        CMD_LLCMD    = 8'h45,
        CMD_RESET    = 8'h80,
        CMD_START    = 8'h90
    } JobCommand;

    typedef struct packed {
        logic        valid;
        logic [7:0]  command;
        logic [63:0] address;
    } JobInterfaceInput;

    typedef struct packed {
        logic        running;
        logic        done;
        logic        cack;
        logic [63:0] error;
        logic        yield;
    } JobInterfaceOutput;

    typedef enum logic [1:0] {
        IDLE,
        RESETTING,
        RUNNING,
        DONE
    } JobState;

    function automatic logic is_command(input JobInterfaceInput j, input JobCommand c);
        return j.valid && (j.command == c);
    endfunction

endpackage

// File: rtl/job_controller_shift.sv
// rtl/job_controller_shift.sv - single-bit delay pipe with synchronous flush
module shift_register #(
    parameter int DEPTH = 2
) (
    input  logic i_clock,
    input  logic i_flush,
    input  logic i_data,
    output logic o_data
);

    logic [DEPTH-1:0] r_stages;

    always_ff @(posedge i_clock) begin
        if (i_flush) begin
            r_stages <= '0;
        end else begin
            r_stages[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stages[i] <= r_stages[i-1];
            end
        end
    end

    assign o_data = r_stages[DEPTH-1];

endmodule

// File: rtl/job_controller.sv
// rtl/job_controller.sv - PSL job command decode, core reset sequencing and done/error reporting
module job_controller
    import job_controller_pkg::*;
#(
    parameter int RESET_CYCLES = 4,
    parameter int DONE_DELAY   = 2,
    parameter int ERR_WIDTH    = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  JobInterfaceInput     job_in,
    output JobInterfaceOutput    job_out,
    output logic                 core_reset,
    output logic                 core_start,
    output logic [63:0]          wed,
    input  logic                 core_done,
    input  logic                 core_error_valid,
    input  logic [ERR_WIDTH-1:0] core_error
);

    localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);

    JobState          r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_running;
    logic             r_start;
    logic             r_done_event;
    logic [63:0]      r_wed;
    logic [63:0]      r_error;

    logic             w_cmd_reset;
    logic             w_cmd_start;
    logic             w_flush;
    logic             w_done;
    logic [63:0]      w_error_ext;

    assign w_cmd_reset = is_command(job_in, CMD_RESET);
    assign w_cmd_start = is_command(job_in, CMD_START);
    assign w_flush     = reset || w_cmd_reset;

    always_comb begin
        w_error_ext = '0;
        w_error_ext[ERR_WIDTH-1:0] = core_error;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_running    <= 1'b0;
            r_start      <= 1'b0;
            r_done_event <= 1'b0;
            r_wed        <= '0;
            r_error      <= '0;
        end else begin
            r_start      <= 1'b0;
            r_done_event <= 1'b0;
            // RESET preempts everything, including a done/error seen in the same cycle
            if (w_cmd_reset) begin
                r_state   <= RESETTING;
                r_count   <= RESET_LOAD;
                r_running <= 1'b0;
                r_wed     <= '0;
                r_error   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_cmd_start) begin
                            r_wed     <= job_in.address;
                            r_start   <= 1'b1;
                            r_running <= 1'b1;
                            r_state   <= RUNNING;
                        end
                    end
                    RESETTING: begin
                        if (r_count == '0) begin
                            r_done_event <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_count <= r_count - 1'b1;
                        end
                    end
                    RUNNING: begin
                        // Error takes priority so a simultaneous done yields a single event
                        if (core_error_valid) begin
                            r_error      <= w_error_ext;
                            r_done_event <= 1'b1;
                            r_running    <= 1'b0;
                            r_state      <= IDLE;
                        end else if (core_done) begin
                            r_done_event <= 1'b1;
                            r_running    <= 1'b0;
                            r_state      <= DONE;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    shift_register #(
        .DEPTH(DONE_DELAY)
    ) u_done_pipe (
        .i_clock(clock),
        .i_flush(w_flush),
        .i_data (r_done_event),
        .o_data (w_done)
    );

    assign core_reset = reset || (r_state == RESETTING);
    assign core_start = r_start;
    assign wed        = r_wed;

    always_comb begin
        job_out         = '0;
        job_out.running = r_running;
        job_out.done    = w_done;
        job_out.cack    = 1'b0;
        job_out.error   = r_error;
        job_out.yield   = 1'b0;
    end

endmodule

// File: tb/tb_job_controller.sv
// tb/tb_job_controller.sv - scoreboard bench for job_controller with timestamp-based reference model
module tb_job_controller;
    import job_controller_pkg::*;

    localparam int RC   = 4;
    localparam int DD   = 2;
    localparam int EW   = 16;
    localparam int MAXC = 4096;

    logic              clock = 1'b0;
    logic              reset;
    JobInterfaceInput  job_in;
    JobInterfaceOutput job_out;
    logic              core_reset;
    logic              core_start;
    logic [63:0]       wed;
    logic              core_done;
    logic              core_error_valid;
    logic [EW-1:0]     core_error;

    job_controller #(
        .RESET_CYCLES(RC),
        .DONE_DELAY  (DD),
        .ERR_WIDTH   (EW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .job_in          (job_in),
        .job_out         (job_out),
        .core_reset      (core_reset),
        .core_start      (core_start),
        .wed             (wed),
        .core_done       (core_done),
        .core_error_valid(core_error_valid),
        .core_error      (core_error)
    );

    always #5 clock = ~clock;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Expected per-cycle levels, indexed by the cycle in which they must be visible
    bit          exp_run [MAXC];
    bit          exp_crst[MAXC];
    logic [63:0] exp_wed [MAXC];
    logic [63:0] exp_err [MAXC];
    // Expected pulse cycles, in order
    int done_q[$];
    int start_q[$];

    bit          m_running     = 1'b0;
    int          m_reset_end   = -1;
    int          m_accept_from = 0;
    logic [63:0] m_wed         = '0;
    logic [63:0] m_err         = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Inputs presented during cycle c take effect on the state seen in cycle c+1
    task automatic model_step(input int c, input bit rst, input bit v, input logic [7:0] cmd,
                              input logic [63:0] a, input bit cd, input bit ev, input logic [EW-1:0] ce);
        bit is_reset_cmd;
        bit is_start;
        is_reset_cmd = v && (cmd == CMD_RESET);
        is_start     = v && (cmd == CMD_START);
        if (rst || is_reset_cmd) begin
            while (done_q.size() > 0 && done_q[$] > c) void'(done_q.pop_back());
            while (start_q.size() > 0 && start_q[$] > c) void'(start_q.pop_back());
            m_running   = 1'b0;
            m_wed       = '0;
            m_err       = '0;
            m_reset_end = rst ? -1 : c + RC;
            if (!rst) done_q.push_back(c + RC + DD + 1);
        end else if (c <= m_reset_end) begin
            m_running = 1'b0;
        end else if (m_running) begin
            if (ev) begin
                m_err         = 64'(ce);
                m_running     = 1'b0;
                m_accept_from = c + 1;
                done_q.push_back(c + 1 + DD);
            end else if (cd) begin
                m_running     = 1'b0;
                m_accept_from = c + 2;
                done_q.push_back(c + 1 + DD);
            end
        end else if (is_start && c >= m_accept_from) begin
            m_wed     = a;
            m_running = 1'b1;
            start_q.push_back(c + 1);
        end
        exp_run[c+1]  = m_running;
        exp_crst[c+1] = (c + 1 <= m_reset_end);
        exp_wed[c+1]  = m_wed;
        exp_err[c+1]  = m_err;
    endtask

    task automatic drive(input bit rst, input bit v, input logic [7:0] cmd, input logic [63:0] a,
                         input bit cd, input bit ev, input logic [EW-1:0] ce);
        @(posedge clock);
        cyc++;
        #1;
        reset              = rst;
        job_in.valid       = v;
        job_in.command     = cmd;
        job_in.address     = a;
        core_done          = cd;
        core_error_valid   = ev;
        core_error         = ce;
        model_step(cyc, rst, v, cmd, a, cd, ev, ce);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, '0);
    endtask

    task automatic send(input logic [7:0] c, input logic [63:0] a);
        drive(1'b0, 1'b1, c, a, 1'b0, 1'b0, '0);
    endtask

    always @(negedge clock) begin
        if (cyc > 0) begin
            check("running", 64'(job_out.running), 64'(exp_run[cyc]));
            check("core_reset", 64'(core_reset), 64'(reset | exp_crst[cyc]));
            check("wed", wed, exp_wed[cyc]);
            check("error", job_out.error, exp_err[cyc]);
            check("cack_yield", 64'({job_out.cack, job_out.yield}), 64'h0);

            while (done_q.size() > 0 && done_q[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL done_missed: no done pulse, expected at cycle %0d", done_q.pop_front());
            end
            if (job_out.done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: done=1 at cycle %0d, expected none", cyc);
                end else begin
                    check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
                end
            end

            while (start_q.size() > 0 && start_q[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL start_missed: no core_start, expected at cycle %0d", start_q.pop_front());
            end
            if (core_start) begin
                if (start_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL start_unexpected: core_start=1 at cycle %0d, expected none", cyc);
                end else begin
                    check("start_cycle", 64'(cyc), 64'(start_q.pop_front()));
                end
            end
        end
    end

    int          r_sel;
    bit          r_rst;
    bit          r_v;
    bit          r_cd;
    bit          r_ev;
    logic [7:0]  r_cmd;
    logic [63:0] r_addr;

    initial begin
        reset            = 1'b1;
        job_in           = '0;
        core_done        = 1'b0;
        core_error_valid = 1'b0;
        core_error       = '0;
        model_step(0, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, '0);

        repeat (3) drive(1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, '0);

        // RESET after reset release, then a normal job
        send(CMD_RESET, 64'h0);
        idle(10);
        send(CMD_START, 64'h0000_1000_0000_0040);
        idle(4);
        drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, '0);
        idle(6);

        // Error path, second START accepted, RESET clears error
        send(CMD_START, 64'h2000);
        idle(3);
        drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1, 16'hDEAD);
        send(CMD_START, 64'h3000);
        idle(3);
        drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, '0);
        idle(4);
        send(CMD_RESET, 64'h0);
        idle(10);

        // Simultaneous done and error
        send(CMD_START, 64'h4000);
        idle(2);
        drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b1, 16'h0005);
        idle(6);

        // RESET one cycle after core_done flushes the pending done
        send(CMD_START, 64'h5000);
        idle(2);
        drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, '0);
        send(CMD_RESET, 64'h0);
        idle(10);

        // Ignored events
        send(CMD_START, 64'h6000);
        idle(2);
        send(CMD_START, 64'h7777);
        send(CMD_TIMEBASE, 64'hFFFF);
        send(CMD_LLCMD, 64'h1234);
        idle(2);
        drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, '0);
        idle(6);
        drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, '0);
        idle(6);

        // Synchronous reset while running
        send(CMD_START, 64'h8000);
        idle(2);
        drive(1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, '0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            r_v   = ($urandom_range(0, 4) == 0);
            r_sel = $urandom_range(0, 9);
            case (r_sel)
                0:             r_cmd = CMD_RESET;
                1, 2, 3, 4, 5: r_cmd = CMD_START;
                6, 7:          r_cmd = CMD_TIMEBASE;
                8:             r_cmd = CMD_LLCMD;
                default:       r_cmd = 8'($urandom);
            endcase
            r_addr = {$urandom, $urandom};
            r_cd   = ($urandom_range(0, 7) == 0);
            r_ev   = ($urandom_range(0, 24) == 0);
            drive(r_rst, r_v, r_cmd, r_addr, r_cd, r_ev, EW'($urandom));
        end
        idle(20);

        check("done_queue_drained", 64'(done_q.size()), 64'h0);
        check("start_queue_drained", 64'(start_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
